// File: rtl/bbox_tracker.sv
// bbox_tracker: frame-difference motion detector that accumulates a bounding box
// over FRAMES_PER_RESULT frames, publishes it with valid/ready and draws it on the video.
module bbox_tracker #(
  parameter int                   PIX_W             = 8,
  parameter int                   IMG_W             = 640,
  parameter int                   IMG_H             = 480,
  parameter int                   COORD_W           = 12,
  parameter int                   FRAMES_PER_RESULT = 10,
  parameter int                   MIN_PIXELS        = 16,
  parameter int                   CNT_W             = 20,
  parameter logic [3*PIX_W-1:0]   BOX_COLOR         = 24'hFF0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pix_valid,
  input  logic                 sof,
  input  logic [PIX_W-1:0]     pix_a,
  input  logic [PIX_W-1:0]     pix_b,
  input  logic [PIX_W-1:0]     threshold,
  output logic                 ovl_valid,
  output logic [3*PIX_W-1:0]   ovl_pix,
  output logic                 box_valid,
  input  logic                 box_ready,
  output logic [COORD_W-1:0]   box_xmin,
  output logic [COORD_W-1:0]   box_xmax,
  output logic [COORD_W-1:0]   box_ymin,
  output logic [COORD_W-1:0]   box_ymax,
  output logic [CNT_W-1:0]     box_count,
  output logic                 box_present,
  output logic                 box_overrun
);

  localparam logic [0:0] ST_SYNC = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
  localparam int FCNT_W = (FRAMES_PER_RESULT > 1) ? $clog2(FRAMES_PER_RESULT) : 1;
  localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST  = COORD_W'(IMG_H - 1);
  localparam logic [FCNT_W-1:0]  F_LAST  = FCNT_W'(FRAMES_PER_RESULT - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]   MIN_CNT = CNT_W'(MIN_PIXELS);

  logic [0:0]          state_q, state_d;
  logic [COORD_W-1:0]  x_q, x_d, y_q, y_d;
  logic [FCNT_W-1:0]   frame_q, frame_d;
  logic [COORD_W-1:0]  xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [COORD_W-1:0]  box_xmin_q, box_xmin_d, box_xmax_q, box_xmax_d;
  logic [COORD_W-1:0]  box_ymin_q, box_ymin_d, box_ymax_q, box_ymax_d;
  logic [CNT_W-1:0]    box_count_q, box_count_d;
  logic                box_present_q, box_present_d;
  logic                box_valid_q, box_valid_d;
  logic                box_overrun_q, box_overrun_d;
  logic                ovl_valid_q, ovl_valid_d;
  logic [3*PIX_W-1:0]  ovl_pix_q, ovl_pix_d;

  logic [PIX_W:0]      diff;
  logic                motion, accept, frame_done, publish, on_border;
  logic [COORD_W-1:0]  cur_x, cur_y;
  logic [COORD_W-1:0]  hit_xmin, hit_xmax, hit_ymin, hit_ymax;
  logic [CNT_W-1:0]    hit_cnt;

  // Pixel acceptance, motion test and raster position.
  always_comb begin
    if (pix_a >= pix_b) begin
      diff = {1'b0, pix_a} - {1'b0, pix_b};
    end else begin
      diff = {1'b0, pix_b} - {1'b0, pix_a};
    end
    motion     = diff > {1'b0, threshold};
    accept     = pix_valid && ((state_q == ST_RUN) || sof);
    cur_x      = sof ? {COORD_W{1'b0}} : x_q;
    cur_y      = sof ? {COORD_W{1'b0}} : y_q;
    frame_done = accept && (cur_x == X_LAST) && (cur_y == Y_LAST);
    publish    = frame_done && (frame_q == F_LAST);
    state_d    = (accept && sof) ? ST_RUN : state_q;
    x_d        = x_q;
    y_d        = y_q;
    frame_d    = frame_q;
    if (accept) begin
      if (cur_x == X_LAST) begin
        x_d = {COORD_W{1'b0}};
        y_d = (cur_y == Y_LAST) ? {COORD_W{1'b0}} : cur_y + COORD_W'(1);
      end else begin
        x_d = cur_x + COORD_W'(1);
        y_d = cur_y;
      end
    end else begin
      x_d = x_q;
      y_d = y_q;
    end
    if (frame_done) begin
      frame_d = (frame_q == F_LAST) ? {FCNT_W{1'b0}} : frame_q + FCNT_W'(1);
    end else begin
      frame_d = frame_q;
    end
  end

  // Accumulators fold in the current pixel; a publish hands them to the box and clears them.
  always_comb begin
    hit_xmin = (accept && motion && (cur_x < xmin_q)) ? cur_x : xmin_q;
    hit_xmax = (accept && motion && (cur_x > xmax_q)) ? cur_x : xmax_q;
    hit_ymin = (accept && motion && (cur_y < ymin_q)) ? cur_y : ymin_q;
    hit_ymax = (accept && motion && (cur_y > ymax_q)) ? cur_y : ymax_q;
    hit_cnt  = (accept && motion && (cnt_q != CNT_MAX)) ? cnt_q + CNT_W'(1) : cnt_q;
    if (publish) begin
      xmin_d        = {COORD_W{1'b1}};
      xmax_d        = {COORD_W{1'b0}};
      ymin_d        = {COORD_W{1'b1}};
      ymax_d        = {COORD_W{1'b0}};
      cnt_d         = {CNT_W{1'b0}};
      box_xmin_d    = hit_xmin;
      box_xmax_d    = hit_xmax;
      box_ymin_d    = hit_ymin;
      box_ymax_d    = hit_ymax;
      box_count_d   = hit_cnt;
      box_present_d = hit_cnt >= MIN_CNT;
    end else begin
      xmin_d        = hit_xmin;
      xmax_d        = hit_xmax;
      ymin_d        = hit_ymin;
      ymax_d        = hit_ymax;
      cnt_d         = hit_cnt;
      box_xmin_d    = box_xmin_q;
      box_xmax_d    = box_xmax_q;
      box_ymin_d    = box_ymin_q;
      box_ymax_d    = box_ymax_q;
      box_count_d   = box_count_q;
      box_present_d = box_present_q;
    end
  end

  // Result handshake and overlay; the overlay always uses the box currently held on the outputs.
  always_comb begin
    if (publish) begin
      box_valid_d = 1'b1;
    end else if (box_valid_q && box_ready) begin
      box_valid_d = 1'b0;
    end else begin
      box_valid_d = box_valid_q;
    end
    box_overrun_d = box_overrun_q || (publish && box_valid_q && !box_ready);
    on_border = (((cur_x == box_xmin_q) || (cur_x == box_xmax_q)) &&
                 (cur_y >= box_ymin_q) && (cur_y <= box_ymax_q)) ||
                (((cur_y == box_ymin_q) || (cur_y == box_ymax_q)) &&
                 (cur_x >= box_xmin_q) && (cur_x <= box_xmax_q));
    ovl_valid_d = accept;
    if (accept) begin
      ovl_pix_d = (box_present_q && on_border) ? BOX_COLOR : {pix_a, pix_a, pix_a};
    end else begin
      ovl_pix_d = ovl_pix_q;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_SYNC;
      x_q           <= {COORD_W{1'b0}};
      y_q           <= {COORD_W{1'b0}};
      frame_q       <= {FCNT_W{1'b0}};
      xmin_q        <= {COORD_W{1'b1}};
      xmax_q        <= {COORD_W{1'b0}};
      ymin_q        <= {COORD_W{1'b1}};
      ymax_q        <= {COORD_W{1'b0}};
      cnt_q         <= {CNT_W{1'b0}};
      box_xmin_q    <= {COORD_W{1'b0}};
      box_xmax_q    <= {COORD_W{1'b0}};
      box_ymin_q    <= {COORD_W{1'b0}};
      box_ymax_q    <= {COORD_W{1'b0}};
      box_count_q   <= {CNT_W{1'b0}};
      box_present_q <= 1'b0;
      box_valid_q   <= 1'b0;
      box_overrun_q <= 1'b0;
      ovl_valid_q   <= 1'b0;
      ovl_pix_q     <= {(3*PIX_W){1'b0}};
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_q       <= frame_d;
      xmin_q        <= xmin_d;
      xmax_q        <= xmax_d;
      ymin_q        <= ymin_d;
      ymax_q        <= ymax_d;
      cnt_q         <= cnt_d;
      box_xmin_q    <= box_xmin_d;
      box_xmax_q    <= box_xmax_d;
      box_ymin_q    <= box_ymin_d;
      box_ymax_q    <= box_ymax_d;
      box_count_q   <= box_count_d;
      box_present_q <= box_present_d;
      box_valid_q   <= box_valid_d;
      box_overrun_q <= box_overrun_d;
      ovl_valid_q   <= ovl_valid_d;
      ovl_pix_q     <= ovl_pix_d;
    end
  end

  assign ovl_valid   = ovl_valid_q;
  assign ovl_pix     = ovl_pix_q;
  assign box_valid   = box_valid_q;
  assign box_xmin    = box_xmin_q;
  assign box_xmax    = box_xmax_q;
  assign box_ymin    = box_ymin_q;
  assign box_ymax    = box_ymax_q;
  assign box_count   = box_count_q;
  assign box_present = box_present_q;
  assign box_overrun = box_overrun_q;

endmodule

// File: doc/bbox_tracker.md
BBOX_TRACKER -- requirements
Module: bbox_tracker

Interface
REQ-001 Parameter PIX_W, 8, grey pixel width.
REQ-002 Parameter IMG_W, 640, active pixels per line.
REQ-003 Parameter IMG_H, 480, active lines per frame.
REQ-004 Parameter COORD_W, 12, coordinate width; IMG_W and IMG_H SHALL each be at most 2^COORD_W.
REQ-005 Parameter FRAMES_PER_RESULT, 10, frames accumulated per published box (>=1).
REQ-006 Parameter MIN_PIXELS, 16, minimum motion-pixel count for a box to be present.
REQ-007 Parameter CNT_W, 20, motion-pixel counter width.
REQ-008 Parameter BOX_COLOR, 24'hFF0000, overlay border colour {R,G,B}.
REQ-009 clk  in  1  single clock; all logic on its rising edge.
REQ-010 rst  in  1  synchronous, active-high reset.
REQ-011 pix_valid  in  1  pixel strobe; pix_a, pix_b and sof are sampled only when high.
REQ-012 sof  in  1  marks the first pixel of a frame.
REQ-013 pix_a, pix_b  in  PIX_W each  current-frame and previous-frame pixels.
REQ-014 threshold  in  PIX_W  motion threshold.
REQ-015 ovl_valid  out  1; ovl_pix  out  3*PIX_W  overlay video {R,G,B}.
REQ-016 box_valid  out  1; box_ready  in  1  result handshake.
REQ-017 box_xmin, box_xmax, box_ymin, box_ymax  out  COORD_W each; box_count  out  CNT_W; box_present  out  1; box_overrun  out  1.

Function
REQ-018 The FSM SHALL have two states, SYNC and RUN; reset enters SYNC; a pixel with pix_valid&sof enters RUN and is processed as pixel (0,0); pixels in SYNC without sof SHALL be ignored.
REQ-019 In RUN, each accepted pixel SHALL advance x; x wraps from IMG_W-1 to 0 and increments y; y wraps from IMG_H-1 to 0.
REQ-020 sof in RUN SHALL force the current pixel to (0,0); the interrupted frame SHALL NOT be counted, and accumulators SHALL keep their contents.
REQ-021 motion = (|pix_a - pix_b| > threshold), strictly greater, computed at PIX_W+1 bits without wrap.
REQ-022 On a motion pixel, accumulators SHALL update: xmin=min, xmax=max, ymin=min, ymax=max, cnt+1 saturating at 2^CNT_W-1; cleared values are xmin=ymin=all-ones, xmax=ymax=0, cnt=0.
REQ-023 Accepting pixel (IMG_W-1, IMG_H-1) completes a frame and increments the frame counter modulo FRAMES_PER_RESULT.
REQ-024 Completing frame FRAMES_PER_RESULT-1 SHALL publish in the next cycle: box_* = accumulators including that last pixel; box_present = (cnt >= MIN_PIXELS); accumulators cleared in the same cycle.
REQ-025 Publish SHALL set box_valid=1; box_valid SHALL clear on the cycle after box_valid&box_ready unless a new publish occurs in that cycle.
REQ-026 A publish while box_valid&!box_ready SHALL overwrite outputs and set sticky box_overrun, which clears only on rst.
REQ-027 Overlay latency SHALL be 1 cycle: ovl_valid = registered pix_valid (in RUN, or the entering sof pixel).
REQ-028 ovl_pix SHALL be BOX_COLOR when box_present and the pixel lies on the last published box border: (x==box_xmin or x==box_xmax) with box_ymin<=y<=box_ymax, or (y==box_ymin or y==box_ymax) with box_xmin<=x<=box_xmax; otherwise {pix_a,pix_a,pix_a}.
REQ-029 The overlay SHALL use the published box independent of the handshake; a box published mid-frame SHALL apply from the next pixel.

Reset
REQ-030 On rst: state=SYNC; x=y=0; frame counter=0; accumulators cleared; box_valid=0, box_present=0, box_overrun=0, box_* =0, box_count=0, ovl_valid=0, ovl_pix=0.
REQ-031 rst asserted mid-frame SHALL discard all partial results; the first frame after it starts at the next sof.

Verification (IMG_W=8, IMG_H=4, FRAMES_PER_RESULT=2, MIN_PIXELS=2)
REQ-032 Two frames, threshold=10, diff=20 at (2,1),(5,3) in frame 0 and (1,2) in frame 1 -> one cycle after the last pixel: box_valid=1, box=(1,5,1,3), box_count=3, box_present=1.
REQ-033 diff exactly equal to threshold at every pixel -> box_count=0, box_present=0, xmin=ymin=all-ones; overlay equals grey input with 1-cycle latency.
REQ-034 box_ready held low across two publishes -> second result shown, box_overrun=1 and stays 1; box_ready=1 -> box_valid drops on the following cycle.
REQ-035 Pixels before the first sof -> no ovl_valid and no accumulation; sof at x=4 mid-frame -> position resets to (0,0), frame counter unchanged.
REQ-036 After publishing box (1,5,1,3): pixel (1,2) -> ovl_pix=24'hFF0000; pixel (3,2) -> grey; rst mid-frame -> all outputs 0 next cycle, state SYNC.
